// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - operand/result bundle for the bit-serial subtractor
//
// Purpose: groups the request (start, a, b) and result (busy, done, d, bout, zero)
// signals of serial_subtractor into one port.
// Ports (via modports):
//   master : drives start/a/b, observes busy/done/d/bout/zero
//   slave  : observes start/a/b, drives busy/done/d/bout/zero
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             zero;

    modport master (
        output start, a, b,
        input  busy, done, d, bout, zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, d, bout, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, one bit per clock, LSB first
//
// Purpose: computes d = a - b mod 2^WIDTH and the final borrow over WIDTH clock
// edges. A start seen in IDLE captures the operands; WIDTH RUN edges process one
// bit each; one DONE cycle pulses done, then back to IDLE.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - serial_subtractor_if.slave: start/a/b in, busy/done/d/bout/zero out
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_subtractor_if.slave    bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             bor;
    logic [CW-1:0]    cnt;

    logic             diff;
    logic             bor_next;
    logic [WIDTH-1:0] res_next;

    // Full-subtractor on the current LSBs; the new difference bit enters the
    // result register from the MSB side so after WIDTH shifts bit 0 lands at [0].
    always_comb begin
        diff     = a_sh[0] ^ b_sh[0] ^ bor;
        bor_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bor);
        res_next = {diff, res[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            res      <= '0;
            bor      <= 1'b0;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.d    <= '0;
            bus.bout <= 1'b0;
            bus.zero <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        a_sh     <= bus.a;
                        b_sh     <= bus.b;
                        bor      <= 1'b0;
                        cnt      <= '0;
                        state    <= RUN;
                        bus.busy <= 1'b1;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    res  <= res_next;
                    bor  <= bor_next;
                    cnt  <= cnt + 1'b1;
                    // Published outputs change only here, so they stay stable
                    // while a later operation is still shifting.
                    if (cnt == CW'(WIDTH - 1)) begin
                        state    <= DONE;
                        cnt      <= '0;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.d    <= res_next;
                        bus.bout <= bor_next;
                        bus.zero <= (res_next == '0);
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (WIDTH 8 and 4)
module tb_serial_subtractor;
    logic clk;
    logic rst;

    serial_subtractor_if #(.WIDTH(8)) if8 ();
    serial_subtractor_if #(.WIDTH(4)) if4 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 0;
    int done_cnt8 = 0;
    int done_cnt4 = 0;

    // Reference model, index 0 = WIDTH 8, index 1 = WIDTH 4. Tracks only the
    // externally visible contract: an op takes WIDTH edges after acceptance,
    // then done for one cycle, then idle.
    int m_busy[2];
    int m_done[2];
    int m_left[2];
    int m_a[2];
    int m_b[2];
    int m_d[2];
    int m_bout[2];
    int m_zero[2];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input int w, input logic s, input int av, input int bv);
        int mask;
        mask = (1 << w) - 1;
        if (rst) begin
            m_busy[k] = 0; m_done[k] = 0; m_left[k] = 0;
            m_d[k] = 0; m_bout[k] = 0; m_zero[k] = 1;
        end else if (m_done[k] != 0) begin
            m_done[k] = 0;
        end else if (m_busy[k] != 0) begin
            m_left[k]--;
            if (m_left[k] == 0) begin
                m_busy[k] = 0;
                m_done[k] = 1;
                m_d[k]    = (m_a[k] - m_b[k]) & mask;
                m_bout[k] = int'(m_a[k] < m_b[k]);
                m_zero[k] = int'(m_d[k] == 0);
            end
        end else if (s) begin
            m_busy[k] = 1;
            m_left[k] = w;
            m_a[k]    = av;
            m_b[k]    = bv;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 8, if8.start, int'(if8.a), int'(if8.b));
        model_step(1, 4, if4.start, int'(if4.a), int'(if4.b));
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("busy8", int'(if8.busy), m_busy[0]);
            chk("done8", int'(if8.done), m_done[0]);
            chk("d8",    int'(if8.d),    m_d[0]);
            chk("bout8", int'(if8.bout), m_bout[0]);
            chk("zero8", int'(if8.zero), m_zero[0]);
            chk("busy4", int'(if4.busy), m_busy[1]);
            chk("done4", int'(if4.done), m_done[1]);
            chk("d4",    int'(if4.d),    m_d[1]);
            chk("bout4", int'(if4.bout), m_bout[1]);
            chk("zero4", int'(if4.zero), m_zero[1]);
            if (if8.done) done_cnt8++;
            if (if4.done) done_cnt4++;
        end
    end

    // Called at posedge+#1 with the 8-bit unit idle. With hold set, start stays
    // high through RUN and DONE with swapped operands, which must be ignored.
    task automatic run_op8(input int av, input int bv, input int ed, input int eb,
                           input int ez, input bit hold);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        if8.start = 1'b1;
        if8.a = 8'(av);
        if8.b = 8'(bv);
        @(posedge clk); #1;
        n = 1;
        if (hold) begin
            if8.a = 8'(bv);
            if8.b = 8'(av);
        end else begin
            if8.start = 1'b0;
            if8.a = ~8'(av);
            if8.b = ~8'(bv);
        end
        while (!seen && n < 20) begin
            @(negedge clk);
            if (if8.done) seen = 1;
            else begin
                @(posedge clk);
                n++;
            end
        end
        chk("done_seen", int'(seen), 1);
        chk("latency_edges", n, 9);
        chk("lit_d", int'(if8.d), ed);
        chk("lit_bout", int'(if8.bout), eb);
        chk("lit_zero", int'(if8.zero), ez);
        @(posedge clk); #1;
        if8.start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        if8.start = 1'b0; if8.a = '0; if8.b = '0;
        if4.start = 1'b0; if4.a = '0; if4.b = '0;
        @(posedge clk); #1;
        checking = 1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", int'(if8.busy), 0);
        chk("rst_done", int'(if8.done), 0);
        chk("rst_d", int'(if8.d), 0);
        chk("rst_bout", int'(if8.bout), 0);
        chk("rst_zero", int'(if8.zero), 1);
        @(posedge clk); #1;

        run_op8(200, 55, 145, 0, 0, 0);
        run_op8(5, 10, 251, 1, 0, 0);
        run_op8(8'h3C, 8'h3C, 0, 0, 1, 0);
        run_op8(8'h00, 8'hFF, 1, 1, 0, 0);

        // Abort mid-run: reset lands on the 4th RUN edge, with a start alongside
        if8.start = 1'b1; if8.a = 8'd200; if8.b = 8'd55;
        @(posedge clk); #1;
        if8.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        if8.start = 1'b1; if8.a = 8'd9; if8.b = 8'd3;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", int'(if8.busy), 0);
        chk("abort_done", int'(if8.done), 0);
        chk("abort_d", int'(if8.d), 0);
        chk("abort_zero", int'(if8.zero), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        if8.start = 1'b0;
        repeat (12) begin
            @(negedge clk);
            chk("abort_no_busy", int'(if8.busy), 0);
            chk("abort_no_done", int'(if8.done), 0);
        end
        @(posedge clk); #1;
        run_op8(9, 3, 6, 0, 0, 0);

        // Start held through RUN and DONE must yield exactly one result
        run_op8(100, 1, 99, 0, 0, 1);
        repeat (12) begin
            @(negedge clk);
            chk("hold_d", int'(if8.d), 99);
            chk("hold_bout", int'(if8.bout), 0);
            chk("hold_no_done", int'(if8.done), 0);
        end
        @(posedge clk); #1;

        // Exhaustive WIDTH=4 at the minimum issue interval of 6 cycles
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                if4.start = 1'b1;
                if4.a = 4'(ia);
                if4.b = 4'(ib);
                @(posedge clk); #1;
                if4.start = 1'b0;
                if4.a = ~4'(ia);
                if4.b = 4'(ia);
                repeat (5) @(posedge clk);
                #1;
            end
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("done4_count", done_cnt4, 256);
        chk("done8_count", done_cnt8, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
